// File: rtl/osd_num_display.sv
// Single-digit seven-segment OSD overlay flag generator.
// Raster position in, per-pixel overlay flag out, two clocks later, aligned with the delayed video path.
module osd_num_display #(
  parameter int          OSD_WIDTH  = 16,
  parameter int          OSD_HEIGHT = 32,
  parameter logic [12:0] OSD_X      = 13'd8,
  parameter logic [12:0] OSD_Y      = 13'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  num,
  input  logic [12:0] pos_x,
  input  logic [12:0] pos_y,
  input  logic        pos_de,
  input  logic        pos_vs,
  output logic        pos_en
);

  // Box limits are widened to 14 bits so OSD_X + OSD_WIDTH cannot wrap.
  localparam logic [13:0] X_END = {1'b0, OSD_X} + 14'(OSD_WIDTH);
  localparam logic [13:0] Y_END = {1'b0, OSD_Y} + 14'(OSD_HEIGHT);

  localparam logic [3:0] DIGIT_BLANK = 4'd10;

  // Segment vector layout: [6]=a [5]=b [4]=c [3]=d [2]=e [1]=f [0]=g.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  function automatic logic [6:0] digit_segs(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  function automatic logic in_rng5(input logic [4:0] v, input logic [4:0] lo, input logic [4:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic in_rng4(input logic [3:0] v, input logic [3:0] lo, input logic [3:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Which segment rectangles contain the pixel at (row, col) of the glyph box.
  function automatic logic [6:0] seg_cover(input logic [4:0] row, input logic [3:0] col);
    logic [6:0] c;
    logic       col_mid;
    logic       col_left;
    logic       col_right;
    col_mid   = in_rng4(col, 4'd3, 4'd12);
    col_left  = in_rng4(col, 4'd2, 4'd4);
    col_right = in_rng4(col, 4'd11, 4'd13);
    c         = '0;
    c[SEG_A]  = in_rng5(row, 5'd2, 5'd4) && col_mid;
    c[SEG_G]  = in_rng5(row, 5'd14, 5'd16) && col_mid;
    c[SEG_D]  = in_rng5(row, 5'd27, 5'd29) && col_mid;
    c[SEG_F]  = in_rng5(row, 5'd3, 5'd15) && col_left;
    c[SEG_B]  = in_rng5(row, 5'd3, 5'd15) && col_right;
    c[SEG_E]  = in_rng5(row, 5'd16, 5'd28) && col_left;
    c[SEG_C]  = in_rng5(row, 5'd16, 5'd28) && col_right;
    return c;
  endfunction

  // Frame-sync edge detector and digit latch.
  logic       vs_q;
  logic       vs_d;
  logic [3:0] digit_q;
  logic [3:0] digit_d;
  logic       vs_rise;

  // Stage 1 registers.
  logic       box_q;
  logic       box_d;
  logic [3:0] col_q;
  logic [3:0] col_d;
  logic [4:0] row_q;
  logic [4:0] row_d;
  logic [3:0] s1_digit_q;
  logic [3:0] s1_digit_d;

  // Stage 2 register.
  logic       pos_en_q;
  logic       pos_en_d;

  always_comb begin
    vs_rise = pos_vs && !vs_q;
    vs_d    = pos_vs;
    digit_d = vs_rise ? num : digit_q;
  end

  always_comb begin
    box_d = pos_de
         && (pos_x >= OSD_X) && ({1'b0, pos_x} < X_END)
         && (pos_y >= OSD_Y) && ({1'b0, pos_y} < Y_END);
    col_d      = 4'(pos_x - OSD_X);
    row_d      = 5'(pos_y - OSD_Y);
    // Stage 1 takes the digit held before this edge; a new latch value applies from the next pixel.
    s1_digit_d = digit_q;
  end

  always_comb begin
    pos_en_d = box_q && (|(digit_segs(s1_digit_q) & seg_cover(row_q, col_q)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q       <= 1'b0;
      digit_q    <= DIGIT_BLANK;
      box_q      <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      s1_digit_q <= '0;
      pos_en_q   <= 1'b0;
    end else begin
      vs_q       <= vs_d;
      digit_q    <= digit_d;
      box_q      <= box_d;
      col_q      <= col_d;
      row_q      <= row_d;
      s1_digit_q <= s1_digit_d;
      pos_en_q   <= pos_en_d;
    end
  end

  assign pos_en = pos_en_q;

endmodule

// File: tb/tb_osd_num_display.sv
// Directed bench for osd_num_display: driver pushes hand-derived expectations,
// a negedge monitor pops them two clocks after the matching input.
module tb_osd_num_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  num = 4'd0;
  logic [12:0] pos_x = '0;
  logic [12:0] pos_y = '0;
  logic        pos_de = 1'b0;
  logic        pos_vs = 1'b0;
  logic        pos_en;

  osd_num_display dut (
    .clk    (clk),
    .rst    (rst),
    .num    (num),
    .pos_x  (pos_x),
    .pos_y  (pos_y),
    .pos_de (pos_de),
    .pos_vs (pos_vs),
    .pos_en (pos_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [0:0] exp_q[$];
  int         stamp_q[$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] cur_num = 4'd0;

  // Segment probe points (row, col), one per segment a..g.
  int          probe_r[7] = '{3, 8, 22, 28, 22, 8, 15};
  int          probe_c[7] = '{7, 12, 12, 7, 3, 3, 7};
  // Segment sets per digit, bit 6 = a ... bit 0 = g.
  logic [6:0]  seg_tab[10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  task automatic drive(input logic r, input logic vs, input logic [3:0] n, input logic de,
                       input logic [12:0] x, input logic [12:0] y, input logic e);
    @(posedge clk);
    #1;
    rst    = r;
    pos_vs = vs;
    num    = n;
    pos_de = de;
    pos_x  = x;
    pos_y  = y;
    exp_q.push_back(e);
    stamp_q.push_back(cyc);
  endtask

  // Active pixel at glyph (row, col) using the current num input, no sync.
  task automatic pix(input int r, input int c, input logic e);
    drive(1'b0, 1'b0, cur_num, 1'b1, 13'(8 + c), 13'(8 + r), e);
  endtask

  task automatic latch(input logic [3:0] n);
    cur_num = n;
    drive(1'b0, 1'b1, n, 1'b0, 13'd0, 13'd0, 1'b0);
    drive(1'b0, 1'b0, n, 1'b0, 13'd0, 13'd0, 1'b0);
  endtask

  // Monitor: each output is checked two clocks after its input was applied.
  initial begin
    logic [0:0] e;
    int         s;
    forever begin
      @(negedge clk);
      while (stamp_q.size() > 0 && stamp_q[0] + 2 <= cyc) begin
        e = exp_q.pop_front();
        s = stamp_q.pop_front();
        total++;
        if (pos_en !== e[0] || s + 2 != cyc) begin
          bad++;
          $display("FAIL pos_en input_cyc=%0d check_cyc=%0d got=%b exp=%b", s, cyc, pos_en, e[0]);
        end
      end
    end
  end

  initial begin
    // Reset held with an in-box pixel, then blank digit without any sync edge.
    cur_num = 4'd8;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'd8, 1'b1, 13'd13, 13'd11, 1'b0);
    pix(3, 5, 1'b0);
    pix(15, 6, 1'b0);

    // Latch 8 and check latency.
    latch(4'd8);
    pix(3, 5, 1'b1);
    pix(3, 0, 1'b0);
    pix(20, 3, 1'b1);

    // Digit 1: right-hand verticals only.
    latch(4'd1);
    for (int c = 0; c < 16; c++) pix(20, c, (c >= 11 && c <= 13));
    for (int c = 0; c < 16; c++) pix(2, c, 1'b0);

    // Box edges with digit 8.
    latch(4'd8);
    drive(1'b0, 1'b0, 4'd8, 1'b1, 13'd7, 13'd23, 1'b0);
    pix(15, 15, 1'b0);
    for (int c = 3; c <= 12; c++) pix(15, c, 1'b1);
    pix(15, 2, 1'b1);
    pix(15, 14, 1'b0);
    pix(28, 6, 1'b1);
    pix(31, 6, 1'b0);
    drive(1'b0, 1'b0, 4'd8, 1'b1, 13'd8, 13'd40, 1'b0);
    drive(1'b0, 1'b0, 4'd8, 1'b1, 13'd14, 13'd40, 1'b0);
    drive(1'b0, 1'b0, 4'd8, 1'b1, 13'd20, 13'd40, 1'b0);
    drive(1'b0, 1'b0, 4'd8, 1'b1, 13'd14, 13'd7, 1'b0);

    // Blank codes over the whole box.
    latch(4'd12);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 16; c++) pix(r, c, 1'b0);
    latch(4'd15);
    pix(28, 6, 1'b0);

    // DE gating with digit 0.
    latch(4'd0);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 13'd13, 13'd11, 1'b0);
    pix(3, 5, 1'b1);

    // num changes without a sync edge: digit stays 0 (no g) until the next edge.
    cur_num = 4'd8;
    pix(15, 6, 1'b0);
    latch(4'd8);
    pix(15, 6, 1'b1);

    // Every digit at one probe point per segment.
    for (int d = 0; d < 10; d++) begin
      latch(4'(d));
      for (int s = 0; s < 7; s++) pix(probe_r[s], probe_c[s], seg_tab[d][6 - s]);
    end

    // pos_vs held high: no retrigger; edge coinciding with a pixel applies from the next pixel.
    drive(1'b0, 1'b1, 4'd3, 1'b0, 13'd0, 13'd0, 1'b0);
    drive(1'b0, 1'b1, 4'd8, 1'b1, 13'd11, 13'd30, 1'b0);
    drive(1'b0, 1'b1, 4'd8, 1'b1, 13'd11, 13'd30, 1'b0);
    drive(1'b0, 1'b0, 4'd8, 1'b1, 13'd11, 13'd30, 1'b0);
    drive(1'b0, 1'b1, 4'd8, 1'b1, 13'd11, 13'd30, 1'b0);
    drive(1'b0, 1'b0, 4'd8, 1'b1, 13'd11, 13'd30, 1'b1);

    // Mid-frame reset: the pixel just before rst is killed, then blank until a sync edge.
    cur_num = 4'd8;
    pix(22, 3, 1'b1);
    pix(22, 3, 1'b0);
    drive(1'b1, 1'b0, 4'd8, 1'b1, 13'd11, 13'd30, 1'b0);
    pix(22, 3, 1'b0);
    pix(15, 6, 1'b0);
    latch(4'd8);
    pix(22, 3, 1'b1);

    // Drain.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 4'd8, 1'b0, 13'd0, 13'd0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
